// File: rtl/store_write_buffer.sv
// store_write_buffer: merging FIFO between the store committer and the memory write port
module store_write_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int BE_WIDTH   = LINE_WIDTH / 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dcWriteReq,
  input  logic [ADDR_WIDTH-1:0] dcWriteAddr,
  input  logic [LINE_WIDTH-1:0] dcWriteData,
  input  logic [BE_WIDTH-1:0]   dcWriteByteWE,
  input  logic                  dcWriteUncachable,
  output logic                  dcWriteReqAck,
  output logic                  dcWriteHit,
  output logic                  dcWriteBusy,
  output logic                  memWriteValid,
  input  logic                  memWriteReady,
  output logic [ADDR_WIDTH-1:0] memWriteAddr,
  output logic [LINE_WIDTH-1:0] memWriteData,
  output logic [BE_WIDTH-1:0]   memWriteByteWE,
  output logic                  memWriteUncachable,
  output logic [$clog2(DEPTH):0] pendingCount
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [LINE_WIDTH-1:0] r_data [DEPTH];
  logic [BE_WIDTH-1:0]   r_be   [DEPTH];
  logic                  r_unc  [DEPTH];
  logic [PW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_ack, r_hit;

  logic [PW-1:0]         w_last;
  logic [ADDR_WIDTH-1:0] w_line;
  logic [LINE_WIDTH-1:0] w_merge_data;
  logic                  w_accept, w_merge, w_push, w_pop, w_valid;

  assign w_valid  = r_count != '0;
  assign w_last   = r_tail - PW'(1);
  assign w_line   = dcWriteAddr & ~ADDR_WIDTH'(BE_WIDTH - 1);
  assign w_accept = dcWriteReq && !dcWriteBusy && !r_ack;
  // The tail is only a merge target when it is not the head, which is frozen while presented
  assign w_merge  = w_accept && r_count >= CW'(2) && !dcWriteUncachable && !r_unc[w_last] && r_addr[w_last] == w_line;
  assign w_push   = w_accept && !w_merge;
  assign w_pop    = w_valid && memWriteReady;

  // Byte-wise overlay of the request onto the youngest entry
  always_comb begin
    w_merge_data = r_data[w_last];
    for (int i = 0; i < BE_WIDTH; i++)
      if (dcWriteByteWE[i]) w_merge_data[8*i +: 8] = dcWriteData[8*i +: 8];
  end

  // Entry storage; stale contents are harmless because occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= w_line;
      r_data[r_tail] <= dcWriteData;
      r_be[r_tail]   <= dcWriteByteWE;
      r_unc[r_tail]  <= dcWriteUncachable;
    end else if (w_merge) begin
      r_data[w_last] <= w_merge_data;
      r_be[w_last]   <= r_be[w_last] | dcWriteByteWE;
    end
  end

  // Pointers, occupancy and the one-cycle acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_head  <= w_pop ? r_head + PW'(1) : r_head;
      r_tail  <= w_push ? r_tail + PW'(1) : r_tail;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_ack   <= w_accept;
      r_hit   <= w_merge;
    end
  end

  assign dcWriteReqAck      = r_ack;
  assign dcWriteHit         = r_hit;
  assign dcWriteBusy        = r_count == CW'(DEPTH);
  assign pendingCount       = r_count;
  assign memWriteValid      = w_valid;
  assign memWriteAddr       = w_valid ? r_addr[r_head] : '0;
  assign memWriteData       = w_valid ? r_data[r_head] : '0;
  assign memWriteByteWE     = w_valid ? r_be[r_head] : '0;
  assign memWriteUncachable = w_valid && r_unc[r_head];
endmodule
